// File: rtl/sd4_operand_loader_pkg.sv
// Shared constants and types for the SD4 operand loader.
// Holds the tap count, per-operand widths, the derived bus widths of the
// packed image/weight buses, and the width of the slot counters.
package sd4_operand_loader_pkg;

  localparam int N_TAPS    = 9;   // operands per window (3x3)
  localparam int PIX_W     = 8;   // pixel width
  localparam int WT_W      = 4;   // SD4 weight width
  localparam int EXP_W     = 5;   // exponent-bias width

  localparam int IMG_BUS_W = N_TAPS * PIX_W;   // 72
  localparam int WT_BUS_W  = N_TAPS * WT_W;    // 36

  // A counter must be able to hold N_TAPS itself (full window).
  localparam int CNT_W     = $clog2(N_TAPS + 1);

  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/sd4_operand_loader_if.sv
// Bus interface of the SD4 operand loader.
// Three streams: weight nibbles in, pixels in, packed bundles out, plus the
// wt_clr pulse.
//   master : the side that feeds operands and consumes bundles
//   slave  : the loader itself
//
// Handshake rule for every stream: a beat transfers on a rising clk edge
// where valid and ready are both 1. Ready may depend combinationally on
// valid-independent state and on wt_clr/out_ready, never on the beat's own
// valid. A source holds valid and data stable until the beat transfers.
interface sd4_operand_loader_if;
  import sd4_operand_loader_pkg::*;

  logic                 wt_clr;
  logic                 wt_valid;
  logic                 wt_ready;
  logic [WT_W-1:0]      wt_data;
  logic [EXP_W-1:0]     exp_bias_in;

  logic                 px_valid;
  logic                 px_ready;
  logic [PIX_W-1:0]     px_data;

  logic                 out_valid;
  logic                 out_ready;
  logic [IMG_BUS_W-1:0] image_out;
  logic [WT_BUS_W-1:0]  weight_out;
  logic [EXP_W-1:0]     exp_bias_out;

  modport master (
    output wt_clr, wt_valid, wt_data, exp_bias_in,
    output px_valid, px_data,
    output out_ready,
    input  wt_ready, px_ready,
    input  out_valid, image_out, weight_out, exp_bias_out
  );

  modport slave (
    input  wt_clr, wt_valid, wt_data, exp_bias_in,
    input  px_valid, px_data,
    input  out_ready,
    output wt_ready, px_ready,
    output out_valid, image_out, weight_out, exp_bias_out
  );

endinterface

// File: rtl/sd4_operand_loader_serial_packer.sv
// sd4_serial_packer: collects N_TAPS serial operands of width W into a flat
// register, operand k at [W*k +: W], with a fill count.
// Ports:
//   clk, rst  clock, asynchronous active-low reset (buffer and count -> 0)
//   clr       drop the partial fill (count -> 0), highest priority
//   restart   buffer has been consumed: count -> 0, or -> 1 when wr_en
//             writes slot 0 in the same cycle
//   wr_en     write data at slot cnt and advance
//   data      operand in
//   bus       packed operands
//   cnt       number of slots filled (0..N_TAPS)
// WRAP=1 returns the count to 0 after the last slot is written (resident
// weight set); WRAP=0 leaves it at N_TAPS until restart (pixel window).
module sd4_serial_packer #(
  parameter int N_TAPS = 9,
  parameter int W      = 8,
  parameter bit WRAP   = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         restart,
  input  logic                         wr_en,
  input  logic [W-1:0]                 data,
  output logic [N_TAPS*W-1:0]          bus,
  output logic [$clog2(N_TAPS+1)-1:0]  cnt
);

  localparam int CNT_W = $clog2(N_TAPS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TAPS - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(N_TAPS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus <= '0;
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (restart) begin
      if (wr_en) begin
        bus[0 +: W] <= data;
        cnt         <= CNT_W'(1);
      end else begin
        cnt <= '0;
      end
    end else if (wr_en && (cnt < FULL)) begin
      // A write into a full buffer is ignored, so the count never passes N_TAPS.
      bus[cnt*W +: W] <= data;
      cnt             <= (WRAP && (cnt == LAST)) ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sd4_operand_loader.sv
// sd4_operand_loader: front end of the SD4 MAC.
// Loads a resident weight set (N_TAPS nibbles plus exponent bias), then
// gathers pixel windows of N_TAPS bytes. It emits one registered
// {image, weight, exp_bias} bundle per window on a valid/ready output.
// Ports:
//   clk  clock
//   rst  asynchronous active-low reset
//   ldr  loader bus (slave side): weight stream, pixel stream, bundle output
//        and the wt_clr pulse
module sd4_operand_loader
  import sd4_operand_loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  sd4_operand_loader_if.slave  ldr
);

  logic                 wts_valid;
  logic [EXP_W-1:0]     exp_bias_q;
  logic [WT_BUS_W-1:0]  wt_bus;
  logic [IMG_BUS_W-1:0] px_bus;
  cnt_t                 wt_cnt;
  cnt_t                 px_cnt;
  logic                 wt_fire;
  logic                 wt_last;
  logic                 px_fire;
  logic                 move;

  // wt_clr wins over every same-cycle handshake, so both readies drop with it.
  assign ldr.wt_ready = !wts_valid && !ldr.wt_clr;
  assign wt_fire      = ldr.wt_valid && ldr.wt_ready;
  assign wt_last      = wt_fire && (wt_cnt == cnt_t'(N_TAPS - 1));

  // A full window moves to the output register when that register is free or
  // drains this cycle. The freed slot 0 accepts a pixel in the same cycle,
  // which keeps the stream at one pixel per clock.
  assign move         = (px_cnt == cnt_t'(N_TAPS)) && (!ldr.out_valid || ldr.out_ready)
                        && !ldr.wt_clr;
  assign ldr.px_ready = wts_valid && !ldr.wt_clr
                        && ((px_cnt < cnt_t'(N_TAPS)) || move);
  assign px_fire      = ldr.px_valid && ldr.px_ready;

  sd4_serial_packer #(.N_TAPS(N_TAPS), .W(WT_W), .WRAP(1'b1)) u_wt_packer (
    .clk     (clk),
    .rst     (rst),
    .clr     (ldr.wt_clr),
    .restart (1'b0),
    .wr_en   (wt_fire),
    .data    (ldr.wt_data),
    .bus     (wt_bus),
    .cnt     (wt_cnt)
  );

  sd4_serial_packer #(.N_TAPS(N_TAPS), .W(PIX_W), .WRAP(1'b0)) u_px_packer (
    .clk     (clk),
    .rst     (rst),
    .clr     (ldr.wt_clr),
    .restart (move),
    .wr_en   (px_fire),
    .data    (ldr.px_data),
    .bus     (px_bus),
    .cnt     (px_cnt)
  );

  // The weight set becomes usable on the edge that stores its last nibble.
  // The bias is captured together with that nibble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wts_valid  <= 1'b0;
      exp_bias_q <= '0;
    end else if (ldr.wt_clr) begin
      wts_valid  <= 1'b0;
    end else if (wt_last) begin
      wts_valid  <= 1'b1;
      exp_bias_q <= ldr.exp_bias_in;
    end
  end

  // Output register. wt_clr does not touch it, so a pending bundle keeps the
  // weights it was built with.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ldr.out_valid    <= 1'b0;
      ldr.image_out    <= '0;
      ldr.weight_out   <= '0;
      ldr.exp_bias_out <= '0;
    end else if (move) begin
      ldr.out_valid    <= 1'b1;
      ldr.image_out    <= px_bus;
      ldr.weight_out   <= wt_bus;
      ldr.exp_bias_out <= exp_bias_q;
    end else if (ldr.out_ready) begin
      ldr.out_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sd4_operand_loader.sv
// Bench for sd4_operand_loader: directed vectors, a queue-based reference
// model checked every cycle, and literal checks on delivered bundles.
module tb_sd4_operand_loader;
  import sd4_operand_loader_pkg::*;

  localparam int BUN_W = IMG_BUS_W + WT_BUS_W + EXP_W;
  typedef logic [BUN_W-1:0] bundle_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sd4_operand_loader_if lif ();

  sd4_operand_loader dut (
    .clk (clk),
    .rst (rst),
    .ldr (lif)
  );

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int stalls = 0;
  bit stall_watch = 1'b0;
  bundle_t got_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Window is a queue of accepted pixels; weights are a queue until N_TAPS
  // nibbles arrive; the output is one bundle slot.
  logic [PIX_W-1:0]     win[$];
  logic [WT_W-1:0]      wq[$];
  bit                   m_wv = 1'b0;
  bit                   m_ov = 1'b0;
  bundle_t              m_out = '0;
  logic [WT_BUS_W-1:0]  m_w = '0;
  logic [EXP_W-1:0]     m_b = '0;
  logic [IMG_BUS_W-1:0] m_img;
  bit                   full, mv, e_wt_ready, e_px_ready;

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_wt_ready", lif.wt_ready, !lif.wt_clr);
      chk("rst_px_ready", lif.px_ready, 1'b0);
      chk("rst_out_valid", lif.out_valid, 1'b0);
      chk("rst_bundle", {lif.image_out, lif.weight_out, lif.exp_bias_out}, '0);
      win.delete();
      wq.delete();
      m_wv = 1'b0; m_ov = 1'b0; m_out = '0; m_w = '0; m_b = '0;
    end else begin
      full       = (win.size() == N_TAPS);
      e_wt_ready = !m_wv && !lif.wt_clr;
      mv         = full && (!m_ov || lif.out_ready) && !lif.wt_clr;
      e_px_ready = m_wv && !lif.wt_clr && (!full || mv);

      chk("wt_ready", lif.wt_ready, e_wt_ready);
      chk("px_ready", lif.px_ready, e_px_ready);
      chk("out_valid", lif.out_valid, m_ov);
      if (m_ov)
        chk("bundle", {lif.image_out, lif.weight_out, lif.exp_bias_out}, m_out);

      if (stall_watch && lif.px_valid && !lif.px_ready) stalls++;
      if (lif.out_valid && lif.out_ready)
        got_q.push_back({lif.image_out, lif.weight_out, lif.exp_bias_out});

      if (mv) begin
        for (int k = 0; k < N_TAPS; k++) m_img[k*PIX_W +: PIX_W] = win[k];
        m_out = {m_img, m_w, m_b};
        m_ov  = 1'b1;
        win.delete();
      end else if (lif.out_ready) begin
        m_ov = 1'b0;
      end
      if (lif.px_valid && e_px_ready) win.push_back(lif.px_data);

      if (lif.wt_clr) begin
        wq.delete();
        win.delete();
        m_wv = 1'b0;
      end else if (lif.wt_valid && e_wt_ready) begin
        wq.push_back(lif.wt_data);
        if (wq.size() == N_TAPS) begin
          for (int k = 0; k < N_TAPS; k++) m_w[k*WT_W +: WT_W] = wq[k];
          m_b  = lif.exp_bias_in;
          m_wv = 1'b1;
          wq.delete();
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wt_push(input logic [WT_W-1:0] d, input logic [EXP_W-1:0] b);
    int t = 0;
    lif.wt_valid = 1'b1; lif.wt_data = d; lif.exp_bias_in = b;
    @(negedge clk);
    while (!lif.wt_ready && t < 50) begin @(negedge clk); t++; end
    if (!lif.wt_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL wt_timeout: wt_ready stayed %0b, required 1", lif.wt_ready);
    end
    @(posedge clk); #1;
    lif.wt_valid = 1'b0;
  endtask

  task automatic load_weights(input logic [WT_BUS_W-1:0] w, input logic [EXP_W-1:0] b);
    for (int k = 0; k < N_TAPS; k++) wt_push(w[k*WT_W +: WT_W], b);
  endtask

  task automatic px_push(input logic [PIX_W-1:0] d);
    int t = 0;
    lif.px_valid = 1'b1; lif.px_data = d;
    @(negedge clk);
    while (!lif.px_ready && t < 50) begin @(negedge clk); t++; end
    if (!lif.px_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL px_timeout: px_ready stayed %0b, required 1", lif.px_ready);
    end
    @(posedge clk); #1;
    lif.px_valid = 1'b0;
  endtask

  task automatic px_run(input logic [PIX_W-1:0] base, input int n);
    for (int i = 0; i < n; i++) px_push(base + PIX_W'(i));
  endtask

  // ---------------- directed tests ----------------
  initial begin
    lif.wt_clr = 1'b0; lif.wt_valid = 1'b0; lif.wt_data = '0; lif.exp_bias_in = '0;
    lif.px_valid = 1'b0; lif.px_data = '0; lif.out_ready = 1'b0;

    // Reset state
    cycles(3);
    @(negedge clk);
    chk("reset_wt_ready", lif.wt_ready, 1'b1);
    chk("reset_image", lif.image_out, '0);
    @(posedge clk); #1 rst = 1'b1;
    cycles(1);

    // Weight load: nibbles 1..9, bias 3
    load_weights(36'h987654321, 5'd3);
    @(negedge clk);
    chk("wt_ready_after_load", lif.wt_ready, 1'b0);
    chk("px_ready_after_load", lif.px_ready, 1'b1);
    @(posedge clk); #1;

    // First window, latency
    lif.out_ready = 1'b1;
    px_run(8'h10, 9);
    @(negedge clk);
    chk("latency_not_yet", lif.out_valid, 1'b0);
    @(negedge clk);
    chk("latency_valid", lif.out_valid, 1'b1);
    chk("first_image", lif.image_out, 72'h181716151413121110);
    chk("first_weight", lif.weight_out, 36'h987654321);
    chk("first_bias", lif.exp_bias_out, 5'd3);
    cycles(3);

    // 27 back-to-back pixels
    got_q.delete();
    stalls = 0; stall_watch = 1'b1;
    px_run(8'h20, 27);
    stall_watch = 1'b0;
    cycles(4);
    chk("b2b_bundles", got_q.size(), 3);
    chk("b2b_stalls", stalls, 0);
    if (got_q.size() == 3)
      chk("b2b_third_image", got_q[2][WT_BUS_W+EXP_W +: IMG_BUS_W], 72'h3a3938373635343332);

    // Backpressure: out_ready low, 18 pixels offered
    got_q.delete();
    lif.out_ready = 1'b0;
    px_run(8'h40, 18);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("bp_px_ready_low", lif.px_ready, 1'b0);
    end
    chk("bp_out_valid", lif.out_valid, 1'b1);
    chk("bp_image_held", lif.image_out, 72'h484746454443424140);
    cycles(1);
    lif.out_ready = 1'b1;
    cycles(5);
    chk("bp_bundles", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("bp_order_0", got_q[0][WT_BUS_W+EXP_W +: IMG_BUS_W], 72'h484746454443424140);
      chk("bp_order_1", got_q[1][WT_BUS_W+EXP_W +: IMG_BUS_W], 72'h51504f4e4d4c4b4a49);
    end

    // wt_clr with a bundle pending and a partial window
    got_q.delete();
    lif.out_ready = 1'b0;
    px_run(8'h50, 9);
    px_run(8'h60, 4);
    lif.wt_clr = 1'b1;
    @(posedge clk); #1 lif.wt_clr = 1'b0;
    @(negedge clk);
    chk("clr_px_ready", lif.px_ready, 1'b0);
    chk("clr_wt_ready", lif.wt_ready, 1'b1);
    chk("clr_out_kept", lif.out_valid, 1'b1);
    @(posedge clk); #1;
    load_weights(36'h789abcdef, 5'd17);
    lif.out_ready = 1'b1;
    px_run(8'h70, 9);
    cycles(4);
    chk("clr_bundles", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("clr_old_bundle", got_q[0], {72'h585756555453525150, 36'h987654321, 5'd3});
      chk("clr_new_bundle", got_q[1], {72'h787776757473727170, 36'h789abcdef, 5'd17});
    end

    // Reset mid-window
    px_run(8'h80, 4);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", lif.out_valid, 1'b0);
    chk("mid_rst_image", lif.image_out, '0);
    chk("mid_rst_weight", lif.weight_out, '0);
    chk("mid_rst_wt_ready", lif.wt_ready, 1'b1);
    chk("mid_rst_px_ready", lif.px_ready, 1'b0);
    cycles(2);
    rst = 1'b1;
    cycles(1);

    // Reset mid-weight-load, then recover
    for (int k = 0; k < 5; k++) wt_push(4'h5, 5'd9);
    rst = 1'b0;
    @(negedge clk);
    chk("wl_rst_wt_ready", lif.wt_ready, 1'b1);
    chk("wl_rst_px_ready", lif.px_ready, 1'b0);
    chk("wl_rst_bias", lif.exp_bias_out, '0);
    cycles(2);
    rst = 1'b1;
    cycles(1);
    got_q.delete();
    load_weights(36'h123456789, 5'd31);
    px_run(8'h90, 9);
    cycles(4);
    chk("recover_bundles", got_q.size(), 1);
    if (got_q.size() == 1)
      chk("recover_bundle", got_q[0], {72'h989796959493929190, 36'h123456789, 5'd31});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute time bound.
  initial begin
    #200000;
    n_cmp++; n_bad++;
    $display("FAIL global_timeout: simulation time exceeded bound");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
